// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy state encoding and the NOP payload.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with load enable; async reset to RESET_VALUE.
// Latency 1 cycle from wen; no backpressure of its own.
module pipe_data_reg #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wen,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= RESET_VALUE;
      end else if (wen) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a one-beat skid entry.
// Latency 1 cycle; in_ready is a flop, so the skid absorbs the beat sent while the stall propagates.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            count
);

   state_t                  state_q;
   state_t                  state_nxt;
   logic                    in_ready_q;
   logic                    in_fire;
   logic                    out_fire;
   logic                    main_wen;
   logic                    skid_wen;
   logic                    main_from_skid;
   logic [DATA_WIDTH-1:0]   main_din;
   logic [DATA_WIDTH-1:0]   skid_q;

   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign count     = state_q;
   assign main_din  = main_from_skid ? skid_q : in_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_nxt;
         in_ready_q <= (state_nxt != ST_FULL);
      end
   end

   always_comb begin
      state_nxt      = state_q;
      main_wen       = 1'b0;
      skid_wen       = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt = ST_ONE;
               main_wen  = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_wen = 1'b1;
            end else if (in_fire) begin
               state_nxt = ST_FULL;
               skid_wen  = 1'b1;
            end else if (out_fire) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               state_nxt      = ST_ONE;
               main_wen       = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      // Squash drops any incoming beat; stored payloads are left in place.
      if (flush) begin
         state_nxt = ST_EMPTY;
         main_wen  = 1'b0;
         skid_wen  = 1'b0;
      end
   end

   pipe_data_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_main (
      .clk  (clk),
      .rst  (rst),
      .wen  (main_wen),
      .din  (main_din),
      .dout (out_data)
   );

   pipe_data_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .wen  (skid_wen),
      .din  (in_data),
      .dout (skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg against a queue-based occupancy model.
module tb_pipe_skid_reg;
   import pipe_pkg::*;

   localparam int          DW = 64;
   localparam logic [63:0] RV = {32'h0, RV_NOP};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [1:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_skid_reg #(.DATA_WIDTH(DW), .RESET_VALUE(RV)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is a queue of at most two accepted beats, head is visible.
   logic [63:0] mq[$];
   logic [63:0] mcons[$];
   logic [63:0] dut_got[$];
   logic [63:0] m_last = RV;
   logic        m_ifire, m_ofire;
   logic        m_rdy = 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_last = RV;
         m_rdy  = 1'b1;
      end else begin
         m_ifire = in_valid && m_rdy;
         m_ofire = (mq.size() > 0) && out_ready;
         if (m_ofire) mcons.push_back(mq[0]);
         if (flush) begin
            mq.delete();
         end else begin
            if (m_ofire) void'(mq.pop_front());
            if (m_ifire) mq.push_back(in_data);
         end
         if (mq.size() > 0) m_last = mq[0];
         m_rdy = (mq.size() < 2);
      end
   end

   logic        prev_hold = 1'b0;
   logic [63:0] prev_data = '0;

   always @(negedge clk) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_data", out_data, (mq.size() > 0) ? mq[0] : m_last);
      chk("ready_vs_count", 64'(in_ready), 64'(count != 2'd2));
      if (prev_hold && !rst) chk("stall_stable", out_data, prev_data);
      prev_hold = out_valid && !out_ready && !rst;
      prev_data = out_data;
      if (!rst && out_valid && out_ready) dut_got.push_back(out_data);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int base;

   initial begin
      cyc();
      cyc();
      rst = 1'b0;
      chk("init_count", 64'(count), 64'd0);
      chk("init_data", out_data, RV);

      // Reset mid-cycle while FULL with A, B
      in_valid = 1'b1; in_data = 64'hA; out_ready = 1'b0;
      cyc();
      in_data = 64'hB;
      cyc();
      in_valid = 1'b0;
      chk("t1_full", 64'(count), 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("t1_rst_valid", 64'(out_valid), 64'd0);
      chk("t1_rst_ready", 64'(in_ready), 64'd1);
      chk("t1_rst_count", 64'(count), 64'd0);
      chk("t1_rst_data", out_data, RV);
      cyc();
      cyc();
      rst = 1'b0;

      // Streaming 1..4 at full rate
      base = dut_got.size();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'd1;
      for (int i = 2; i <= 4; i++) begin
         cyc();
         chk("t2_data", out_data, 64'(i - 1));
         chk("t2_count", 64'(count), 64'd1);
         in_data = 64'(i);
      end
      cyc();
      chk("t2_last", out_data, 64'd4);
      in_valid = 1'b0;
      cyc();
      chk("t2_empty", 64'(count), 64'd0);
      chk("t2_n", 64'(dut_got.size() - base), 64'd4);
      for (int i = 0; i < 4; i++) chk("t2_seq", dut_got[base + i], 64'(i + 1));

      // Stall with skid absorbing one beat
      base = dut_got.size();
      in_valid = 1'b1; in_data = 64'd5;
      cyc();
      out_ready = 1'b0; in_data = 64'd6;
      cyc();
      chk("t3_count2", 64'(count), 64'd2);
      chk("t3_rdy0", 64'(in_ready), 64'd0);
      in_data = 64'd7;
      cyc();
      chk("t3_hold5", out_data, 64'd5);
      cyc();
      chk("t3_still2", 64'(count), 64'd2);
      out_ready = 1'b1;
      cyc();
      chk("t3_six", out_data, 64'd6);
      chk("t3_count1", 64'(count), 64'd1);
      cyc();
      chk("t3_seven", out_data, 64'd7);
      in_valid = 1'b0;
      cyc();
      chk("t3_n", 64'(dut_got.size() - base), 64'd3);
      for (int i = 0; i < 3; i++) chk("t3_seq", dut_got[base + i], 64'(i + 5));

      // Flush while FULL with a beat offered
      base = dut_got.size();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd8;
      cyc();
      in_data = 64'd9;
      cyc();
      chk("t4_full", 64'(count), 64'd2);
      in_data = 64'd10; flush = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_valid", 64'(out_valid), 64'd0);
      chk("t4_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      cyc();
      cyc();
      chk("t4_none", 64'(dut_got.size() - base), 64'd0);

      // Flush coinciding with an output transfer
      base = dut_got.size();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd11;
      cyc();
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_valid", 64'(out_valid), 64'd0);
      cyc();
      chk("t5_n", 64'(dut_got.size() - base), 64'd1);
      chk("t5_val", dut_got[base], 64'd11);

      // Random traffic
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_data   = {$urandom, $urandom};
         cyc();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      cyc();
      cyc();

      chk("sb_size", 64'(dut_got.size()), 64'(mcons.size()));
      begin
         int nmis = 0;
         for (int i = 0; i < dut_got.size() && i < mcons.size(); i++)
            if (dut_got[i] !== mcons[i]) nmis++;
         chk("sb_order", 64'(nmis), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
